// File: rtl/styler_pkg.sv
// Shared types and sizing for the text-styler line scheduler.
package styler_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int SCANLINES  = 16;
  localparam int SCANLINE_W = 4;
  localparam int ROW_W      = 5;
  localparam int FRAME_W    = 6;
endpackage

// File: rtl/styler_phase_gen.sv
// Derives faint, blink and cursor phases from the frame counter and scanline.
module styler_phase_gen
  import styler_pkg::*;
#(
  parameter int BLINK_BIT  = 5,
  parameter int CURSOR_BIT = 4
) (
  input  logic [FRAME_W-1:0]    frame_cnt,
  input  logic [SCANLINE_W-1:0] scanline,
  output logic                  faint_phase,
  output logic                  blink_phase,
  output logic                  cursor_phase
);
  assign faint_phase  = scanline[0] ^ frame_cnt[0];
  assign blink_phase  = frame_cnt[BLINK_BIT];
  assign cursor_phase = frame_cnt[CURSOR_BIT];

  // Only selected bits matter; fold the rest so the full buses stay in the interface.
  logic unused_bits;
  assign unused_bits = ^{scanline[SCANLINE_W-1:1], frame_cnt};
endmodule

// File: rtl/styler_scheduler.sv
// Walks scanlines and character rows of a frame, handing each line downstream
// with its styling phases, and counts completed frames for blink timing.
module styler_scheduler
  import styler_pkg::*;
#(
  parameter int BLINK_BIT  = 5,
  parameter int CURSOR_BIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ROW_W-1:0]      last_row,
  input  logic                  line_ready,
  output logic                  line_valid,
  output logic [SCANLINE_W-1:0] scanline,
  output logic [ROW_W-1:0]      row,
  output logic                  faint_phase,
  output logic                  blink_phase,
  output logic                  cursor_phase,
  output logic                  frame_done,
  output logic                  busy
);
  localparam logic [SCANLINE_W-1:0] LAST_SCAN = SCANLINE_W'(SCANLINES - 1);

  state_t                state_q, state_d;
  logic [SCANLINE_W-1:0] scan_q;
  logic [ROW_W-1:0]      row_q;
  logic [ROW_W-1:0]      last_row_q;
  logic [FRAME_W-1:0]    frame_q;
  logic                  at_end;

  assign at_end = (scan_q == LAST_SCAN) && (row_q == last_row_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start && !stop) state_d = ST_RUN;
      ST_RUN: begin
        if (stop)                  state_d = ST_IDLE;
        else if (line_ready && at_end) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      scan_q     <= '0;
      row_q      <= '0;
      last_row_q <= '0;
      frame_q    <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            last_row_q <= last_row;
            scan_q     <= '0;
            row_q      <= '0;
          end
        end
        ST_RUN: begin
          // Final line of the frame leaves scanline/row parked at (15, last_row).
          if (!stop && line_ready) begin
            if (scan_q != LAST_SCAN) begin
              scan_q <= scan_q + 1'b1;
            end else if (row_q != last_row_q) begin
              scan_q <= '0;
              row_q  <= row_q + 1'b1;
            end
          end
        end
        ST_DONE: if (!stop) frame_q <= frame_q + 1'b1;
        default: ;
      endcase
    end
  end

  assign line_valid = (state_q == ST_RUN);
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE) && !stop;
  assign scanline   = scan_q;
  assign row        = row_q;

  styler_phase_gen #(
    .BLINK_BIT (BLINK_BIT),
    .CURSOR_BIT(CURSOR_BIT)
  ) u_phase_gen (
    .frame_cnt   (frame_q),
    .scanline    (scan_q),
    .faint_phase (faint_phase),
    .blink_phase (blink_phase),
    .cursor_phase(cursor_phase)
  );
endmodule

// File: tb/tb_styler_scheduler.sv
// Scoreboard bench: a frame-level model queues every expected line and frame end.
module tb_styler_scheduler;
  import styler_pkg::*;

  logic       clk = 1'b0;
  logic       rst, start, stop, line_ready;
  logic [4:0] last_row;
  logic       line_valid, faint_phase, blink_phase, cursor_phase, frame_done, busy;
  logic [3:0] scanline;
  logic [4:0] row;

  styler_scheduler #(.BLINK_BIT(5), .CURSOR_BIT(4)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .last_row(last_row),
    .line_ready(line_ready), .line_valid(line_valid), .scanline(scanline), .row(row),
    .faint_phase(faint_phase), .blink_phase(blink_phase), .cursor_phase(cursor_phase),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int row;
    int scan;
    bit faint;
    bit blink;
    bit cursor;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   fc = 0;          // completed frames modulo 64, as the model sees them
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Every line of a frame in presentation order, then one frame-end marker.
  function automatic void push_frame(input int lr);
    exp_t e;
    for (int r = 0; r <= lr; r++) begin
      for (int s = 0; s < 16; s++) begin
        e.is_done = 1'b0;
        e.row     = r;
        e.scan    = s;
        e.faint   = bit'((s ^ fc) & 1);
        e.blink   = bit'((fc >> 5) & 1);
        e.cursor  = bit'((fc >> 4) & 1);
        q.push_back(e);
      end
    end
    e.is_done = 1'b1;
    q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mon_en && !rst && (line_valid || frame_done)) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output line_valid=%0b frame_done=%0b required=idle",
                 line_valid, frame_done);
      end else if (frame_done) begin
        check("frame_done_expected", frame_done, q[0].is_done);
        check("done_line_valid", line_valid, 0);
        if (q[0].is_done) begin
          void'(q.pop_front());
          fc = (fc + 1) % 64;
        end
      end else begin
        check("frame_done_expected", frame_done, q[0].is_done);
        if (!q[0].is_done) begin
          check("row", row, q[0].row);
          check("scanline", scanline, q[0].scan);
          check("faint_phase", faint_phase, q[0].faint);
          check("blink_phase", blink_phase, q[0].blink);
          check("cursor_phase", cursor_phase, q[0].cursor);
          if (line_ready && !stop) void'(q.pop_front());
        end
      end
    end
  end

  task automatic do_reset();
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0; stop = 1'b0; line_ready = 1'b0; last_row = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    fc = 0;
    mon_en = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_line_valid"}, line_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
    check({tag, "_faint"}, faint_phase, 0);
    check({tag, "_blink"}, blink_phase, 0);
    check({tag, "_cursor"}, cursor_phase, 0);
    check({tag, "_scanline"}, scanline, 0);
    check({tag, "_row"}, row, 0);
  endtask

  // pct < 0 selects a strict 1,0,1,0 line_ready pattern; stop_at is the number
  // of lines consumed before stop is raised (-1 = never).
  task automatic run_frame(input int lr, input int pct, input int stop_at, input bit glitch);
    int total, cyc;
    bit stopped;
    @(posedge clk); #1;
    start = 1'b1; stop = 1'b0; last_row = lr[4:0]; line_ready = 1'b0;
    push_frame(lr);
    total = 16 * (lr + 1) + 1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    stopped = 1'b0;
    while (q.size() > 0 && !stopped && cyc < 5000) begin
      cyc++;
      if (pct < 0) line_ready = cyc[0];
      else         line_ready = ($urandom_range(99) < pct);
      start    = glitch ? 1'($urandom_range(1)) : 1'b0;
      last_row = 5'($urandom);
      if (stop_at >= 0 && (total - q.size()) == stop_at) begin
        stop    = 1'b1;
        stopped = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (q.size() > 0 && !stopped) begin
      checks++;
      failures++;
      $display("FAIL frame_timeout pending=%0d required=0", q.size());
    end
    stop = 1'b0; start = 1'b0; line_ready = 1'b0;
    q.delete();
    @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_line_valid", line_valid, 0);
  endtask

  initial begin
    int done_cyc;
    rst = 1'b1; start = 1'b0; stop = 1'b0; line_ready = 1'b0; last_row = '0;
    do_reset();
    @(negedge clk);
    check_reset_outputs("reset");

    // Two-row frame with line_ready held high: timing of frame end.
    @(posedge clk); #1;
    start = 1'b1; last_row = 5'd1; line_ready = 1'b1;
    push_frame(1);
    done_cyc = 0;
    for (int c = 1; c <= 36; c++) begin
      @(negedge clk);
      if (frame_done && done_cyc == 0) done_cyc = c;
      if (c == 35) check("req036_busy_c35", busy, 0);
      @(posedge clk); #1;
      start = 1'b0; last_row = '0;
    end
    line_ready = 1'b0;
    check("req036_done_cycle", done_cyc, 34);
    check("req036_queue_drained", q.size(), 0);

    // Alternating backpressure, then an abort at row 0 scanline 7.
    run_frame(0, -1, -1, 1'b0);
    run_frame(2, 100, 7, 1'b0);
    check("req038_blink_after_stop", blink_phase, 0);
    run_frame(1, 70, -1, 1'b0);
    // Start requests with different last_row during RUN must be ignored.
    run_frame(1, 80, -1, 1'b1);
    // Abort while in DONE.
    run_frame(0, 100, 16, 1'b0);

    // Blink and cursor timing from a clean frame counter.
    do_reset();
    for (int f = 0; f < 16; f++) run_frame(0, 100, -1, 1'b0);
    check("req039_cursor_16", cursor_phase, 1);
    check("req039_blink_16", blink_phase, 0);
    for (int f = 0; f < 16; f++) run_frame(0, 100, -1, 1'b0);
    check("req039_blink_32", blink_phase, 1);
    check("req039_cursor_32", cursor_phase, 0);

    // Randomised frames with mixed stops, stalls and ignored starts.
    for (int f = 0; f < 24; f++) begin
      int lr, sa;
      lr = $urandom_range(3);
      sa = ($urandom_range(4) == 0) ? $urandom_range(16 * (lr + 1)) : -1;
      run_frame(lr, $urandom_range(100, 40), sa, 1'($urandom_range(1)));
    end

    // Reset in the middle of a frame.
    @(posedge clk); #1;
    start = 1'b1; last_row = 5'd3; line_ready = 1'b1;
    push_frame(3);
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
    end
    mon_en = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("midframe_reset");
    @(posedge clk); #1;
    rst = 1'b0; line_ready = 1'b0;
    q.delete();
    fc = 0;
    @(negedge clk);
    check("post_reset_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/styler_scheduler.md
STYLER_SCHEDULER -- requirements
Module: styler_scheduler

Interface
REQ-001 Parameter BLINK_BIT, default 5, frame-counter bit that drives blink_phase.
REQ-002 Parameter CURSOR_BIT, default 4, frame-counter bit that drives cursor_phase.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request to begin a frame; honoured only in IDLE.
REQ-006 stop  input  1  abort current frame; returns the block to IDLE.
REQ-007 last_row  input  5  index of final character row; sampled on the accepted start.
REQ-008 line_ready  input  1  downstream accepts the current scanline.
REQ-009 line_valid  output  1  scanline/row/phases describe a line to be styled.
REQ-010 scanline  output  4  scanline within character cell, feeds styler scanline input.
REQ-011 row  output  5  current character row.
REQ-012 faint_phase  output  1  faint dither phase.
REQ-013 blink_phase  output  1  text blink phase.
REQ-014 cursor_phase  output  1  cursor blink phase.
REQ-015 frame_done  output  1  one-cycle pulse at normal frame completion.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 States SHALL be IDLE, RUN, DONE; encoding held in the shared package.
REQ-018 IDLE: start=1 and stop=0 SHALL latch last_row, clear scanline and row to 0, and enter RUN next cycle.
REQ-019 line_valid SHALL be 1 exactly when state is RUN.
REQ-020 In RUN, a handshake (line_valid & line_ready) SHALL advance scanline by 1 on the same edge; no advance without line_ready.
REQ-021 Handshake with scanline=15 SHALL wrap scanline to 0 and increment row.
REQ-022 Handshake with scanline=15 and row=latched last_row SHALL enter DONE instead of incrementing row; scanline and row hold their final values (15, last_row) until DONE exits.
REQ-023 DONE SHALL last exactly one cycle, assert frame_done, increment the 6-bit frame counter (wrapping 63->0), and return to IDLE.
REQ-024 stop=1 in RUN or DONE SHALL enter IDLE next cycle, with no frame_done pulse and no frame-counter increment; stop has priority over start and over a concurrent handshake.
REQ-025 start while in RUN or DONE SHALL be ignored; last_row changes outside an accepted start SHALL be ignored.
REQ-026 last_row=0 SHALL yield a 16-line frame (row 0 only).
REQ-027 blink_phase SHALL equal frame_counter[BLINK_BIT]; cursor_phase SHALL equal frame_counter[CURSOR_BIT].
REQ-028 faint_phase SHALL equal scanline[0] XOR frame_counter[0].
REQ-029 Phase outputs SHALL be registered-state functions only (no dependence on line_ready) and stable for the whole duration of a presented line.
REQ-030 In IDLE, scanline and row SHALL hold their last values; frame_done SHALL be 0.

Reset
REQ-031 rst=1 SHALL force state IDLE, scanline=0, row=0, latched last_row=0, frame counter=0 on the next edge.
REQ-032 After reset: line_valid=0, frame_done=0, busy=0, faint_phase=0, blink_phase=0, cursor_phase=0.
REQ-033 rst SHALL override start, stop and handshake, including mid-frame.

Structure
REQ-034 Shared package styler_pkg SHALL hold the state enum, SCANLINES=16, SCANLINE_W=4, ROW_W=5, FRAME_W=6.
REQ-035 Phase logic SHALL be one sub-module, styler_phase_gen (frame counter in, scanline in, three phases out).

Verification
REQ-036 Reset, then start with last_row=1, line_ready held 1 -> 32 handshakes (row 0 scanline 0..15, row 1 scanline 0..15), frame_done pulse on cycle 34 after start, busy low on cycle 35.
REQ-037 line_ready toggled 1,0,1,0 during RUN -> scanline advances only on cycles with line_ready=1; outputs stable while stalled.
REQ-038 stop asserted at row 0 scanline 7 -> IDLE next cycle, no frame_done, frame counter unchanged; following frame still shows blink_phase=0.
REQ-039 Run 16 complete frames with BLINK_BIT=5, CURSOR_BIT=4 -> cursor_phase rises after frame 16, blink_phase still 0; after 32 frames blink_phase=1.
REQ-040 start asserted in RUN with different last_row -> ignored, frame ends at originally latched row; rst mid-frame -> all outputs at reset values next cycle.
